// File: rtl/logic_cmp_pipe.sv
// Two-stage logic/compare pipeline with valid/ready handshakes on both sides.
// S1 holds operands, S2 holds the result; done_cnt counts consumed results.
module logic_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_vld_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             sgn_q;

  logic             s2_vld_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_free;
  logic             s1_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic             lt;
  logic             gt;
  logic [WIDTH-1:0] y_d;
  logic [CNT_W-1:0] cnt_d;

  assign s2_free  = ~s2_vld_q | out_ready;
  assign s1_adv   = s1_vld_q & s2_free;
  assign in_ready = ~s1_vld_q | s2_free;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_vld_q & out_ready;
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_comb begin
    lt = 1'b0;
    gt = 1'b0;
    if (sgn_q) begin
      lt = $signed(a_q) < $signed(b_q);
      gt = $signed(a_q) > $signed(b_q);
    end else begin
      lt = a_q < b_q;
      gt = a_q > b_q;
    end
  end

  always_comb begin
    y_d = '0;
    unique case (op_q)
      3'b000: y_d = ~a_q;
      3'b001: y_d = a_q & b_q;
      3'b010: y_d = a_q | b_q;
      3'b011: y_d = a_q ^ b_q;
      3'b100: y_d = ~(a_q ^ b_q);
      3'b101: y_d = ~(a_q & b_q);
      3'b110: y_d = {{(WIDTH-1){1'b0}}, lt};
      3'b111: y_d = {{(WIDTH-1){1'b0}}, gt};
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sgn_q    <= 1'b0;
    end else if (in_ready) begin
      s1_vld_q <= in_valid;
      if (in_xfer) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        sgn_q <= sgn;
      end
    end
  end

  // Result regs only change when a real entry moves in, so y holds under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
    end else if (s2_free) begin
      s2_vld_q <= s1_vld_q;
      if (s1_adv) begin
        y_q    <= y_d;
        zero_q <= (y_d == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_cmp_pipe.sv
// Directed bench for logic_cmp_pipe: a 32-bit/16-bit-counter instance
// and an 8-bit/4-bit-counter instance for truncation and counter wrap.
module tb_logic_cmp_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        zero;
  logic [15:0] done_cnt;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [2:0]  op8;
  logic        sgn8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  y8;
  logic        zero8;
  logic [3:0]  done_cnt8;

  int nvec;
  int nfail;
  int exp_cnt;

  logic_cmp_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .done_cnt(done_cnt)
  );

  logic_cmp_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .sgn(sgn8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .zero(zero8), .done_cnt(done_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation with out_ready high; returns the S2 contents.
  task automatic run1(input logic [31:0] ta, input logic [31:0] tb_,
                      input logic [2:0] top, input logic tsgn,
                      output logic [31:0] ry, output logic rz,
                      output logic rv);
    a = ta; b = tb_; op = top; sgn = tsgn;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rv = out_valid;
    ry = y;
    rz = zero;
    step();
    exp_cnt++;
  endtask

  task automatic test_reset();
    nvec++;
    if (out_valid !== 1'b0 || y !== 32'h0 || zero !== 1'b1 ||
        done_cnt !== 16'h0 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_state: ov=%b y=%h z=%b cnt=%0d ir=%b want 0 0 1 0 1",
               out_valid, y, zero, done_cnt, in_ready);
    end
  endtask

  task automatic test_stream();
    int base;
    base = exp_cnt;
    out_ready = 1'b1;
    a = 32'hF0F0F0F0; b = 32'hFF00FF00; op = 3'b001; sgn = 1'b0;
    in_valid = 1'b1;
    step();
    op = 3'b100;
    step();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || y !== 32'hF000F000 || zero !== 1'b0) begin
      nfail++;
      $display("FAIL stream_and: ov=%b y=%h z=%b want 1 F000F000 0",
               out_valid, y, zero);
    end
    step();
    nvec++;
    if (out_valid !== 1'b1 || y !== 32'hF00FF00F) begin
      nfail++;
      $display("FAIL stream_xnor: ov=%b y=%h want 1 F00FF00F", out_valid, y);
    end
    step();
    exp_cnt = base + 2;
    nvec++;
    if (out_valid !== 1'b0 || done_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL stream_cnt: ov=%b cnt=%0d want 0 %0d",
               out_valid, done_cnt, exp_cnt);
    end
  endtask

  task automatic test_sign();
    logic [31:0] ry;
    logic        rz;
    logic        rv;
    run1(32'hFFFFFFFF, 32'h1, 3'b110, 1'b1, ry, rz, rv);
    nvec++;
    if (rv !== 1'b1 || ry !== 32'h1) begin
      nfail++;
      $display("FAIL slt_signed: ov=%b y=%h want 1 00000001", rv, ry);
    end
    run1(32'hFFFFFFFF, 32'h1, 3'b110, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'h0 || rz !== 1'b1) begin
      nfail++;
      $display("FAIL slt_unsigned: y=%h z=%b want 0 1", ry, rz);
    end
    run1(32'h80000000, 32'h0, 3'b110, 1'b1, ry, rz, rv);
    nvec++;
    if (ry !== 32'h1) begin
      nfail++;
      $display("FAIL slt_minneg: y=%h want 00000001", ry);
    end
    run1(32'h80000000, 32'h0, 3'b111, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'h1) begin
      nfail++;
      $display("FAIL sgt_unsigned: y=%h want 00000001", ry);
    end
    run1(32'h1234ABCD, 32'h1234ABCD, 3'b110, 1'b1, ry, rz, rv);
    nvec++;
    if (ry !== 32'h0) begin
      nfail++;
      $display("FAIL slt_equal: y=%h want 0", ry);
    end
    run1(32'h1234ABCD, 32'h1234ABCD, 3'b111, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'h0) begin
      nfail++;
      $display("FAIL sgt_equal: y=%h want 0", ry);
    end
  endtask

  task automatic test_zero();
    logic [31:0] ry;
    logic        rz;
    logic        rv;
    run1(32'h12345678, 32'h12345678, 3'b011, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'h0 || rz !== 1'b1) begin
      nfail++;
      $display("FAIL zero_xor: y=%h z=%b want 0 1", ry, rz);
    end
    run1(32'hFFFFFFFF, 32'h0, 3'b000, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'h0 || rz !== 1'b1) begin
      nfail++;
      $display("FAIL zero_not: y=%h z=%b want 0 1", ry, rz);
    end
    run1(32'h1, 32'h0, 3'b010, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'h1 || rz !== 1'b0) begin
      nfail++;
      $display("FAIL zero_or: y=%h z=%b want 1 0", ry, rz);
    end
    run1(32'hFFFFFFFF, 32'h0000FFFF, 3'b101, 1'b0, ry, rz, rv);
    nvec++;
    if (ry !== 32'hFFFF0000 || rz !== 1'b0) begin
      nfail++;
      $display("FAIL nand: y=%h z=%b want FFFF0000 0", ry, rz);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  ops [3];
    logic [31:0] exp [3];
    int acc;
    int base;
    ops[0] = 3'b001; exp[0] = 32'h000F000F;
    ops[1] = 3'b010; exp[1] = 32'h0FFF0FFF;
    ops[2] = 3'b011; exp[2] = 32'h0FF00FF0;
    base = exp_cnt;
    acc = 0;
    out_ready = 1'b0;
    a = 32'h0F0F0F0F; b = 32'h00FF00FF; sgn = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      op = ops[acc < 3 ? acc : 2];
      if (in_ready) acc++;
      step();
      if (c >= 2) begin
        nvec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== exp[0]) begin
          nfail++;
          $display("FAIL bp_stall%0d: ir=%b ov=%b y=%h want 0 1 %h",
                   c, in_ready, out_valid, y, exp[0]);
        end
      end
    end
    nvec++;
    if (acc != 2) begin
      nfail++;
      $display("FAIL bp_accepted: got %0d want 2", acc);
    end
    op = ops[2];
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL bp_ready_comb: ir=%b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      nvec++;
      if (out_valid !== 1'b1 || y !== exp[k]) begin
        nfail++;
        $display("FAIL bp_order%0d: ov=%b y=%h want 1 %h",
                 k, out_valid, y, exp[k]);
      end
      step();
    end
    exp_cnt = base + 3;
    nvec++;
    if (out_valid !== 1'b0 || done_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL bp_drain: ov=%b cnt=%0d want 0 %0d",
               out_valid, done_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ry;
    logic        rz;
    logic        rv;
    out_ready = 1'b0;
    a = 32'hAAAA5555; b = 32'h0; op = 3'b010; sgn = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || done_cnt !== 16'h0 || y !== 32'h0 ||
        zero !== 1'b1 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_async: ov=%b cnt=%0d y=%h z=%b ir=%b want 0 0 0 1 1",
               out_valid, done_cnt, y, zero, in_ready);
    end
    #2 reset = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      nvec++;
      if (out_valid !== 1'b0 || done_cnt !== 16'h0) begin
        nfail++;
        $display("FAIL rst_stale%0d: ov=%b cnt=%0d want 0 0",
                 k, out_valid, done_cnt);
      end
    end
    run1(32'h0000FFFF, 32'h00FF00FF, 3'b001, 1'b0, ry, rz, rv);
    nvec++;
    if (rv !== 1'b1 || ry !== 32'h000000FF || done_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL rst_resume: ov=%b y=%h cnt=%0d want 1 000000FF %0d",
               rv, ry, done_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap8();
    out_ready8 = 1'b1;
    a8 = 8'hF0; b8 = 8'h00; op8 = 3'b001; sgn8 = 1'b0;
    in_valid8 = 1'b1;
    step();
    op8 = 3'b100;
    step();
    nvec++;
    if (out_valid8 !== 1'b1 || y8 !== 8'h00 || zero8 !== 1'b1) begin
      nfail++;
      $display("FAIL w8_and: ov=%b y=%h z=%b want 1 00 1",
               out_valid8, y8, zero8);
    end
    in_valid8 = 1'b0;
    step();
    nvec++;
    if (out_valid8 !== 1'b1 || y8 !== 8'h0F || zero8 !== 1'b0) begin
      nfail++;
      $display("FAIL w8_xnor: ov=%b y=%h z=%b want 1 0F 0",
               out_valid8, y8, zero8);
    end
    step();
    nvec++;
    if (done_cnt8 !== 4'd2) begin
      nfail++;
      $display("FAIL w8_cnt2: cnt=%0d want 2", done_cnt8);
    end
    b8 = 8'h00; op8 = 3'b011;
    in_valid8 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      a8 = 8'(i);
      step();
      if (i >= 1) begin
        nvec++;
        if (out_valid8 !== 1'b1 || y8 !== 8'(i - 1)) begin
          nfail++;
          $display("FAIL w8_flow%0d: ov=%b y=%h want 1 %h",
                   i, out_valid8, y8, 8'(i - 1));
        end
      end
    end
    in_valid8 = 1'b0;
    step();
    step();
    nvec++;
    if (done_cnt8 !== 4'd1 || out_valid8 !== 1'b0) begin
      nfail++;
      $display("FAIL w8_wrap: cnt=%0d ov=%b want 1 0", done_cnt8, out_valid8);
    end
  endtask

  initial begin
    nvec = 0;
    nfail = 0;
    exp_cnt = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0; b = '0; op = '0; sgn = 1'b0;
    out_ready = 1'b1;
    in_valid8 = 1'b0;
    a8 = '0; b8 = '0; op8 = '0; sgn8 = 1'b0;
    out_ready8 = 1'b1;
    #12;
    test_reset();
    reset = 1'b0;
    test_stream();
    test_sign();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_wrap8();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
